uart_top: RTL and testbench

UART_TOP -- requirements
Module: uart_top

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx.sv | 117 +++++++++++
 rtl/uart_tx.sv | 115 +++++++++++
 rtl/uart_top.sv | 53 +++++
 tb/tb_uart_top.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART slice: the FSM state encoding used by both
// transmitter and receiver, default parameter values, and a helper that sizes
// counters from their maximum count.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DEFAULT_DATA_WIDTH   = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

    // Bits needed to hold the values 0 .. n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx
// Receives frames from the serial line. The line is synchronised through two
// flops, a start bit is confirmed half a bit later, then each data bit and the
// stop bit are sampled one bit period apart (mid-bit). A good stop bit loads
// the output word and pulses valid_o; a bad one drops the word.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   line_i  : serial input, idles high
//   data_o  : last correctly received word
//   valid_o : one-cycle pulse when data_o updates
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  line_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CLK_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_d;
    logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  sync1_q, sync2_q;
    logic                  rx_bit;
    logic                  bit_done;

    assign rx_bit   = sync2_q;
    assign bit_done = (clk_cnt_q == CLK_LAST);

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = bit_done ? '0 : clk_cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (!rx_bit) state_d = START;
            end
            START: begin
                // Re-check the start bit half a bit in; a high line means it
                // was a glitch. The counter restarts here so later samples
                // fall mid-bit.
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = rx_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d   = (shift_q >> 1) | (DATA_WIDTH'(rx_bit) << (DATA_WIDTH - 1));
                    bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) state_d = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so the next start edge is not missed.
                if (bit_done) begin
                    state_d = IDLE;
                    if (rx_bit) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // Synchroniser resets to the idle level so leaving reset never
            // looks like a start bit.
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            sync1_q   <= line_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx
// Serialises one DATA_WIDTH word per frame: start bit (0), data LSB first,
// stop bit (1), each bit held for CLKS_PER_BIT clocks. The line is registered
// and idles high.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   valid_i : level request; sampled in IDLE and in the last STOP cycle
//   data_i  : word captured when a frame starts
//   line_o  : serial output
//   busy_o  : high in START, DATA and STOP
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  line_o,
    output logic                  busy_o
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int BIT_W = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CLK_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_d;
    logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  line_q, line_d;
    logic                  bit_done;

    assign bit_done = (clk_cnt_q == CLK_LAST);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        clk_cnt_d = bit_done ? '0 : clk_cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        line_d    = 1'b1;

        unique case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (valid_i) begin
                    shift_d = data_i;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) state_d = STOP;
                end
            end
            STOP: begin
                // A request still pending here starts the next frame with no
                // idle gap.
                if (bit_done) begin
                    if (valid_i) begin
                        shift_d = data_i;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line is registered, so it is derived from the next state and
        // next shift contents; bit 0 of the shift register is the data bit.
        unique case (state_d)
            START:   line_d = 1'b0;
            DATA:    line_d = shift_d[0];
            default: line_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            line_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            line_q    <= line_d;
        end
    end

    assign line_o = line_q;
    assign busy_o = (state_q != IDLE);

endmodule

// File: rtl/uart_top.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_top
// Transmitter and receiver joined by one internal serial line (idle high).
//   t_clk       : clock, rising edge
//   t_rst       : asynchronous active-low reset
//   tx_valid    : level request to send tx_data_in
//   tx_data_in  : word to transmit
//   rx_data_out : last correctly received word
//   rx_valid    : one-cycle pulse when rx_data_out updates
//   tx_busy     : high while a frame is on the line
// -----------------------------------------------------------------------------
module uart_top
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  t_clk,
    input  logic                  t_rst,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    output logic [DATA_WIDTH-1:0] rx_data_out,
    output logic                  rx_valid,
    output logic                  tx_busy
);

    logic serial_line;

    uart_tx #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk_i  (t_clk),
        .rst_ni (t_rst),
        .valid_i(tx_valid),
        .data_i (tx_data_in),
        .line_o (serial_line),
        .busy_o (tx_busy)
    );

    uart_rx #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i  (t_clk),
        .rst_ni (t_rst),
        .line_i (serial_line),
        .data_o (rx_data_out),
        .valid_o(rx_valid)
    );

endmodule

// File: tb/tb_uart_top.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_top
// Directed bench for uart_top with DATA_WIDTH=8, CLKS_PER_BIT=4 (40-cycle
// frames). Inputs change 1 ns after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_uart_top;

    logic       t_clk      = 1'b0;
    logic       t_rst      = 1'b0;
    logic       tx_valid   = 1'b0;
    logic [7:0] tx_data_in = 8'h00;
    logic [7:0] rx_data_out;
    logic       rx_valid;
    logic       tx_busy;

    int n_checks = 0;
    int n_errors = 0;

    bit watch_busy   = 1'b0;
    bit busy_dropped = 1'b0;

    uart_top #(
        .DATA_WIDTH  (8),
        .CLKS_PER_BIT(4)
    ) dut (
        .t_clk      (t_clk),
        .t_rst      (t_rst),
        .tx_valid   (tx_valid),
        .tx_data_in (tx_data_in),
        .rx_data_out(rx_data_out),
        .rx_valid   (rx_valid),
        .tx_busy    (tx_busy)
    );

    always #5 t_clk = ~t_clk;

    always @(negedge t_clk) begin
        if (watch_busy && !tx_busy) busy_dropped = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits up to budget edges for an rx_valid pulse; cycles counts edges.
    task automatic wait_rx(input int budget, output int cycles, output bit got,
                           output logic [7:0] rx_byte, output bit early_nonzero);
        got = 1'b0;
        cycles = 0;
        rx_byte = 8'h00;
        early_nonzero = 1'b0;
        while (!got && cycles < budget) begin
            @(posedge t_clk);
            #1;
            cycles++;
            if (rx_valid) begin
                got = 1'b1;
                rx_byte = rx_data_out;
            end else if (rx_data_out != 8'h00) begin
                early_nonzero = 1'b1;
            end
        end
    endtask

    // One-cycle tx_valid pulse with d, data bus changed to 0 mid-frame,
    // 60 cycles observed. Optionally forces the line low over the stop bit.
    task automatic run_frame(input logic [7:0] d, input bit force_stop,
                             output int busy_cnt, output int pulses,
                             output logic [7:0] rx_byte);
        tx_data_in = d;
        tx_valid = 1'b1;
        busy_cnt = 0;
        pulses = 0;
        rx_byte = 8'h00;
        for (int i = 0; i < 60; i++) begin
            @(posedge t_clk);
            #1;
            if (i == 0) tx_valid = 1'b0;
            if (i == 10) tx_data_in = 8'h00;
            if (force_stop && i == 36) force dut.serial_line = 1'b0;
            if (force_stop && i == 39) release dut.serial_line;
            if (tx_busy) busy_cnt++;
            if (rx_valid) begin
                pulses++;
                rx_byte = rx_data_out;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        bit         got;
        bit         early;
        int         busy_cnt;
        int         pulses;
        logic [7:0] rxb;
        logic [7:0] seq [4];

        seq[0] = 8'h00;
        seq[1] = 8'hFF;
        seq[2] = 8'h01;
        seq[3] = 8'h80;

        // Reset state
        repeat (3) @(posedge t_clk);
        #1;
        check("rst_rx_data", rx_data_out, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_busy", tx_busy, 1'b0);
        t_rst = 1'b1;
        repeat (2) @(posedge t_clk);
        #1;
        check("idle_tx_busy", tx_busy, 1'b0);

        // First frame with tx_valid held: 0xDD within 44 cycles
        tx_data_in = 8'hDD;
        tx_valid = 1'b1;
        wait_rx(44, cyc, got, rxb, early);
        check("first_in_time", got && (cyc <= 44), 1'b1);
        check("first_data", rxb, 8'hDD);
        check("first_no_early_data", early, 1'b0);

        // Back-to-back frames: one rx_valid every 40 cycles, busy held
        busy_dropped = 1'b0;
        watch_busy = 1'b1;
        for (int f = 1; f < 10; f++) begin
            if (f == 9) begin
                watch_busy = 1'b0;
                tx_valid = 1'b0;
            end
            wait_rx(50, cyc, got, rxb, early);
            check($sformatf("b2b_gap_%0d", f), cyc, 40);
            check($sformatf("b2b_data_%0d", f), rxb, 8'hDD);
        end
        check("b2b_busy_held", busy_dropped, 1'b0);
        repeat (20) @(posedge t_clk);
        #1;
        check("b2b_tx_stops", tx_busy, 1'b0);

        // Single pulse, data bus changed mid-frame
        run_frame(8'hA5, 1'b0, busy_cnt, pulses, rxb);
        check("pulse_busy_cycles", busy_cnt, 40);
        check("pulse_rx_count", pulses, 1);
        check("pulse_data", rxb, 8'hA5);

        // Boundary patterns, LSB-first order
        for (int k = 0; k < 4; k++) begin
            run_frame(seq[k], 1'b0, busy_cnt, pulses, rxb);
            check($sformatf("seq_count_%0d", k), pulses, 1);
            check($sformatf("seq_data_%0d", k), rxb, seq[k]);
        end

        // Reset mid-frame
        tx_data_in = 8'h3C;
        tx_valid = 1'b1;
        @(posedge t_clk);
        #1;
        tx_valid = 1'b0;
        repeat (14) @(posedge t_clk);
        #1;
        t_rst = 1'b0;
        #1;
        check("midrst_rx_data", rx_data_out, 8'h00);
        check("midrst_rx_valid", rx_valid, 1'b0);
        check("midrst_tx_busy", tx_busy, 1'b0);
        check("midrst_line_idle", dut.serial_line, 1'b1);
        repeat (2) @(posedge t_clk);
        #1;
        t_rst = 1'b1;
        wait_rx(60, cyc, got, rxb, early);
        check("midrst_no_rx", got, 1'b0);
        check("midrst_data_kept", rx_data_out, 8'h00);
        run_frame(8'h96, 1'b0, busy_cnt, pulses, rxb);
        check("postrst_count", pulses, 1);
        check("postrst_data", rxb, 8'h96);

        // Framing error: stop bit forced low
        run_frame(8'h77, 1'b1, busy_cnt, pulses, rxb);
        check("frame_err_no_rx", pulses, 0);
        check("frame_err_data_kept", rx_data_out, 8'h96);
        run_frame(8'hC3, 1'b0, busy_cnt, pulses, rxb);
        check("recover_count", pulses, 1);
        check("recover_data", rxb, 8'hC3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
